// File: rtl/seq_recursive_mult16_ctrl.sv
// Sequencer for a 2W x 2W product built from four W x W partial products on one shared sub-multiplier.
// Each step is held MUL_LAT+1 cycles; the shifted partial product is accumulated on the last hold cycle.
module seq_recursive_mult16_ctrl #(
    parameter int         HALF_W     = 8,
    parameter int         MUL_LAT    = 0,
    parameter logic [3:0] EXACT_MASK = 4'b1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   a,
    input  logic [2*HALF_W-1:0]   b,
    output logic [HALF_W-1:0]     mul_a,
    output logic [HALF_W-1:0]     mul_b,
    output logic                  mul_en,
    output logic                  mul_exact,
    input  logic [2*HALF_W-1:0]   mul_p,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*HALF_W-1:0]   y,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] LAST_HOLD = 2'(MUL_LAT);

    state_t                state_q;
    logic [2*HALF_W-1:0]   a_q, b_q;
    logic [4*HALF_W:0]     acc_q, acc_d;
    logic [1:0]            step_q, step_d;
    logic [1:0]            hold_q;
    logic                  last_hold;
    logic                  in_ready_q, out_valid_q, busy_q;
    logic                  mul_en_q, mul_exact_q;
    logic [HALF_W-1:0]     mul_a_q, mul_b_q;
    logic [4*HALF_W-1:0]   y_q;

    // Steps 0,1 use the low half of a; steps 0,2 use the low half of b.
    function automatic logic [HALF_W-1:0] op_a(input logic [1:0] k, input logic [2*HALF_W-1:0] av);
        return k[1] ? av[2*HALF_W-1:HALF_W] : av[HALF_W-1:0];
    endfunction

    function automatic logic [HALF_W-1:0] op_b(input logic [1:0] k, input logic [2*HALF_W-1:0] bv);
        return k[0] ? bv[2*HALF_W-1:HALF_W] : bv[HALF_W-1:0];
    endfunction

    function automatic logic [4*HALF_W:0] part_shift(input logic [1:0] k, input logic [2*HALF_W-1:0] p);
        logic [4*HALF_W:0] pe;
        pe = {{(2*HALF_W+1){1'b0}}, p};
        case (k)
            2'd0:    return pe;
            2'd1,
            2'd2:    return pe << HALF_W;
            default: return pe << (2*HALF_W);
        endcase
    endfunction

    always_comb begin
        acc_d     = acc_q + part_shift(step_q, mul_p);
        step_d    = step_q + 2'd1;
        last_hold = (hold_q == LAST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            hold_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mul_en_q    <= 1'b0;
            mul_exact_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            y_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q         <= a;
                        b_q         <= b;
                        acc_q       <= '0;
                        step_q      <= '0;
                        hold_q      <= '0;
                        state_q     <= S_RUN;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        mul_en_q    <= 1'b1;
                        mul_a_q     <= op_a(2'd0, a);
                        mul_b_q     <= op_b(2'd0, b);
                        mul_exact_q <= EXACT_MASK[0];
                    end
                end
                S_RUN: begin
                    if (last_hold) begin
                        hold_q <= '0;
                        acc_q  <= acc_d;
                        if (step_q == 2'd3) begin
                            // Last partial product in; isolate the sub-multiplier while the result waits.
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            y_q         <= acc_d[4*HALF_W-1:0];
                            mul_en_q    <= 1'b0;
                            mul_exact_q <= 1'b0;
                            mul_a_q     <= '0;
                            mul_b_q     <= '0;
                        end else begin
                            step_q      <= step_d;
                            mul_a_q     <= op_a(step_d, a_q);
                            mul_b_q     <= op_b(step_d, b_q);
                            mul_exact_q <= EXACT_MASK[step_d];
                        end
                    end else begin
                        hold_q <= hold_q + 2'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    mul_en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign mul_en    = mul_en_q;
    assign mul_exact = mul_exact_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign y         = y_q;

endmodule

// File: tb/tb_seq_recursive_mult16_ctrl.sv
// Bench with two controllers: index 0 (MUL_LAT=0, all-exact) and index 1 (MUL_LAT=2, exact only on step 3),
// each driving a modelled sub-multiplier (exact product, or product with the low nibble truncated).
module tb_seq_recursive_mult16_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst_n, in_valid, out_ready;
    logic [1:0][15:0]  a_s, b_s;
    logic [1:0]        in_ready, out_valid, busy, mul_en, mul_exact;
    logic [1:0][7:0]   mul_a, mul_b;
    logic [1:0][15:0]  mul_p;
    logic [1:0][31:0]  y;
    logic [15:0]       pipe1, pipe2;

    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] sub(input logic [7:0] x, input logic [7:0] yv, input logic e);
        logic [15:0] p;
        p = 16'(x) * 16'(yv);
        return e ? p : (p & 16'hFFF0);
    endfunction

    function automatic logic [3:0] mask_of(input int d);
        return (d == 0) ? 4'hF : 4'b1000;
    endfunction

    function automatic int per_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference: sum of the four shifted sub-products, modulo 2^32.
    function automatic logic [31:0] model_y(input int d, input logic [15:0] av, input logic [15:0] bv);
        logic [3:0] m;
        longint     s;
        m = mask_of(d);
        s = longint'(sub(av[7:0],  bv[7:0],  m[0]))
          + (longint'(sub(av[7:0],  bv[15:8], m[1])) << 8)
          + (longint'(sub(av[15:8], bv[7:0],  m[2])) << 8)
          + (longint'(sub(av[15:8], bv[15:8], m[3])) << 16);
        return s[31:0];
    endfunction

    assign mul_p[0] = sub(mul_a[0], mul_b[0], mul_exact[0]);
    always @(posedge clk) begin
        pipe1 <= sub(mul_a[1], mul_b[1], mul_exact[1]);
        pipe2 <= pipe1;
    end
    assign mul_p[1] = pipe2;

    seq_recursive_mult16_ctrl #(.HALF_W(8), .MUL_LAT(0), .EXACT_MASK(4'hF)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_s[0]), .b(b_s[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_en(mul_en[0]),
        .mul_exact(mul_exact[0]), .mul_p(mul_p[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .y(y[0]), .busy(busy[0])
    );

    seq_recursive_mult16_ctrl #(.HALF_W(8), .MUL_LAT(2), .EXACT_MASK(4'b1000)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_s[1]), .b(b_s[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_en(mul_en[1]),
        .mul_exact(mul_exact[1]), .mul_p(mul_p[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .y(y[1]), .busy(busy[1])
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // One full transaction: accept, watch every RUN cycle's operands, stall in DONE, then handshake.
    task automatic txn(input int d, input logic [15:0] av, input logic [15:0] bv, input int stall,
                       output logic [31:0] yv, output int lat, output int opbad);
        int         n, k, per;
        logic [3:0] m;
        logic [7:0] ea, eb;
        per   = per_of(d);
        m     = mask_of(d);
        opbad = 0;
        n     = 0;
        while (!in_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) opbad++;
        in_valid[d] = 1'b1;
        a_s[d]      = av;
        b_s[d]      = bv;
        @(negedge clk);
        in_valid[d] = 1'b0;
        a_s[d]      = 16'($urandom);
        b_s[d]      = 16'($urandom);
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            k  = lat / per;
            ea = (k < 2) ? av[7:0] : av[15:8];
            eb = (k % 2 == 0) ? bv[7:0] : bv[15:8];
            if (k > 3) opbad++;
            else if (!mul_en[d] || !busy[d] || in_ready[d] || mul_a[d] !== ea || mul_b[d] !== eb
                     || mul_exact[d] !== m[k]) opbad++;
            @(negedge clk);
            lat++;
        end
        yv = y[d];
        for (int i = 0; i < stall; i++) begin
            in_valid[d] = 1'($urandom);
            a_s[d]      = 16'($urandom);
            b_s[d]      = 16'($urandom);
            if (!out_valid[d] || y[d] !== yv || in_ready[d] || !busy[d] || mul_en[d]) opbad++;
            @(negedge clk);
        end
        in_valid[d]  = 1'b0;
        if (!out_valid[d]) opbad++;
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        if (out_valid[d] || !in_ready[d] || busy[d] || mul_en[d] || mul_a[d] != 8'h0 || mul_b[d] != 8'h0)
            opbad++;
    endtask

    typedef struct {
        int          d;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] y;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] yv;
        int          lat, opbad;
        logic [15:0] ra, rb;

        tbl[0] = '{0, 16'h1234, 16'h5678, 32'h06260060, 4};
        tbl[1] = '{0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 4};
        tbl[2] = '{0, 16'h0000, 16'hABCD, 32'h00000000, 4};
        tbl[3] = '{0, 16'hABCD, 16'h0000, 32'h00000000, 4};
        tbl[4] = '{0, 16'h0003, 16'h0005, 32'h0000000F, 4};
        tbl[5] = '{0, 16'h8000, 16'h0002, 32'h00010000, 4};
        tbl[6] = '{1, 16'h0100, 16'h0100, 32'h00010000, 12};
        tbl[7] = '{1, 16'h0101, 16'h0101, 32'h00010000, 12};
        tbl[8] = '{1, 16'h0000, 16'h0000, 32'h00000000, 12};

        rst_n = 2'b00; in_valid = 2'b00; out_ready = 2'b00;
        a_s = '0; b_s = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_in_ready%0d", d), 64'(in_ready[d]), 64'd1);
            check($sformatf("rst_out_valid%0d", d), 64'(out_valid[d]), 64'd0);
            check($sformatf("rst_busy%0d", d), 64'(busy[d]), 64'd0);
            check($sformatf("rst_y%0d", d), 64'(y[d]), 64'd0);
            check($sformatf("rst_mul%0d", d), {mul_en[d], mul_exact[d], mul_a[d], mul_b[d]}, 64'd0);
        end
        rst_n = 2'b11;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            txn(tbl[i].d, tbl[i].a, tbl[i].b, i % 3, yv, lat, opbad);
            check($sformatf("vec%0d_y", i), 64'(yv), 64'(tbl[i].y));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
            check($sformatf("vec%0d_seq", i), 64'(opbad), 64'd0);
        end

        // Long stall in DONE with in_valid toggling on the input.
        txn(0, 16'h1234, 16'h5678, 5, yv, lat, opbad);
        check("stall_y", 64'(yv), 64'h06260060);
        check("stall_seq", 64'(opbad), 64'd0);
        @(negedge clk);
        check("stall_no_reaccept", 64'({busy[0], out_valid[0], in_ready[0]}), 64'b001);

        // Abort during step k2.
        in_valid[0] = 1'b1; a_s[0] = 16'h1234; b_s[0] = 16'h5678;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_k2_ops", 64'({mul_a[0], mul_b[0]}), 64'h1278);
        rst_n[0] = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid[0]), 64'd0);
        check("abort_in_ready", 64'(in_ready[0]), 64'd1);
        check("abort_mul", 64'({mul_en[0], mul_a[0], mul_b[0]}), 64'd0);
        @(negedge clk);
        check("abort_held", 64'({out_valid[0], busy[0]}), 64'd0);
        rst_n[0] = 1'b1;
        @(negedge clk);
        txn(0, 16'd3, 16'd5, 0, yv, lat, opbad);
        check("post_abort_y", 64'(yv), 64'd15);
        check("post_abort_seq", 64'(opbad), 64'd0);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if (i == 0) ra[7:0] = 8'hFF;
                txn(d, ra, rb, int'($urandom_range(0, 3)), yv, lat, opbad);
                check($sformatf("rnd%0d_%0d_y(a=%0h b=%0h)", d, i, ra, rb), 64'(yv), 64'(model_y(d, ra, rb)));
                check($sformatf("rnd%0d_%0d_lat", d, i), 64'(lat), 64'(4 * per_of(d)));
                check($sformatf("rnd%0d_%0d_seq", d, i), 64'(opbad), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
